irq_pending_arbiter: RTL

IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

---
 rtl/irq_pending_arbiter_pkg.sv | 20 ++
 rtl/irq_pending_arbiter_prio_enc.sv | 20 ++
 rtl/irq_pending_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/irq_pending_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the pending-interrupt arbiter.
package irq_pending_arbiter_pkg;

  localparam int IRQ_W = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One-hot mask for a request index, used to clear the acknowledged bit.
  function automatic logic [IRQ_W-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [IRQ_W-1:0] one;
    one = {{(IRQ_W-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/irq_pending_arbiter_prio_enc.sv
// 8-to-3 priority encoder: reports the highest set input index.
module priority_encoder_83
  import irq_pending_arbiter_pkg::*;
(
  input  logic [IRQ_W-1:0] req,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Captures interrupt events into a pending register and presents them one at
// a time, highest index first, with a one-cycle gap after each acknowledge.
module irq_pending_arbiter
  import irq_pending_arbiter_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq_in,
  input  logic [IRQ_W-1:0] mask,
  input  logic             irq_ack,
  input  logic             ovr_clr,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [IRQ_W-1:0] pending,
  output logic             overrun
);

  state_t           state_reg, state_next;
  logic [IRQ_W-1:0] irq_q_reg;
  logic [IRQ_W-1:0] pending_reg, pending_next;
  logic             overrun_reg, overrun_next;
  logic [ID_W-1:0]  id_reg, id_next;

  logic [IRQ_W-1:0] event_vec;
  logic [IRQ_W-1:0] clear_vec;
  logic [IRQ_W-1:0] sel_req;
  logic [ID_W-1:0]  sel_idx;
  logic             sel_any;
  logic             ack_take;
  logic             ovr_cond;

  // Per-line event detection: rising edge against last cycle, or raw level.
  genvar gi;
  generate
    for (gi = 0; gi < IRQ_W; gi++) begin : g_event
      if (EDGE_MODE != 0) begin : g_edge
        assign event_vec[gi] = irq_in[gi] & ~irq_q_reg[gi];
      end else begin : g_level
        assign event_vec[gi] = irq_in[gi];
      end
    end
  endgenerate

  assign sel_req = pending_reg & mask;

  priority_encoder_83 u_prio (
    .req (sel_req),
    .idx (sel_idx),
    .any (sel_any)
  );

  // An acknowledge only counts while an ID is actually being presented.
  assign ack_take  = (state_reg == SERVE) && irq_ack;
  assign clear_vec = ack_take ? id_onehot(id_reg) : '0;

  // A fresh event on a bit that is still pending (and not being retired
  // this cycle) means an edge was lost; level mode never reports this.
  assign ovr_cond = (EDGE_MODE != 0) && (|(event_vec & pending_reg & ~clear_vec));

  // Pending and overrun update: set beats clear in both cases.
  always_comb begin
    pending_next = (pending_reg & ~clear_vec) | event_vec;
    overrun_next = overrun_reg;
    if (ovr_clr)  overrun_next = 1'b0;
    if (ovr_cond) overrun_next = 1'b1;
  end

  // State, sampled input, pending, overrun and presented ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      irq_q_reg   <= '0;
      pending_reg <= '0;
      overrun_reg <= 1'b0;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      irq_q_reg   <= irq_in;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      id_reg      <= id_next;
    end
  end

  // Next-state logic; the ID is latched only when leaving IDLE so it stays
  // frozen for the whole presentation.
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          id_next    = sel_idx;
          state_next = SERVE;
        end
      end
      SERVE: begin
        if (irq_ack) state_next = GAP;
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are pure functions of the registers.
  always_comb begin
    irq_valid = (state_reg == SERVE);
    irq_id    = id_reg;
    pending   = pending_reg;
    overrun   = overrun_reg;
  end

endmodule
